// File: rtl/endian_swap_pipe.sv
// Pipelined endian swapper with a valid/ready register slice.
// Four permute modes, strobes follow data, 2-entry skid buffer.
module endian_swap_pipe #(
    parameter int DATA_WIDTH = 64,
    parameter int UNIT_WIDTH = 8
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic                             s_valid,
    output logic                             s_ready,
    input  logic [DATA_WIDTH-1:0]            s_data,
    input  logic [DATA_WIDTH/UNIT_WIDTH-1:0] s_strb,
    input  logic [1:0]                       s_mode,
    output logic                             m_valid,
    input  logic                             m_ready,
    output logic [DATA_WIDTH-1:0]            m_data,
    output logic [DATA_WIDTH/UNIT_WIDTH-1:0] m_strb
);

    localparam int NUNIT = DATA_WIDTH / UNIT_WIDTH;
    localparam int HUNIT = NUNIT / 2;

    logic [DATA_WIDTH-1:0] perm_data;
    logic [NUNIT-1:0]      perm_strb;

    logic                  or_v_q, or_v_d;
    logic                  sk_v_q, sk_v_d;
    logic [DATA_WIDTH-1:0] or_data_q, or_data_d;
    logic [DATA_WIDTH-1:0] sk_data_q, sk_data_d;
    logic [NUNIT-1:0]      or_strb_q, or_strb_d;
    logic [NUNIT-1:0]      sk_strb_q, sk_strb_d;

    logic acc;
    logic pop;

    for (genvar j = 0; j < NUNIT; j++) begin : g_unit
        localparam int SRC1 = NUNIT - 1 - j;
        localparam int SRC2 = (j < HUNIT) ? (HUNIT - 1 - j)
                                          : (3 * HUNIT - 1 - j);
        localparam int SRC3 = (j + HUNIT) % NUNIT;

        logic [UNIT_WIDTH-1:0] u_d;
        logic                  u_s;

        // Pick the source unit feeding output unit j
        always_comb begin
            u_d = '0;
            u_s = 1'b0;
            unique case (s_mode)
                2'd0: begin
                    u_d = s_data[j*UNIT_WIDTH +: UNIT_WIDTH];
                    u_s = s_strb[j];
                end
                2'd1: begin
                    u_d = s_data[SRC1*UNIT_WIDTH +: UNIT_WIDTH];
                    u_s = s_strb[SRC1];
                end
                2'd2: begin
                    u_d = s_data[SRC2*UNIT_WIDTH +: UNIT_WIDTH];
                    u_s = s_strb[SRC2];
                end
                2'd3: begin
                    u_d = s_data[SRC3*UNIT_WIDTH +: UNIT_WIDTH];
                    u_s = s_strb[SRC3];
                end
            endcase
        end

        assign perm_data[j*UNIT_WIDTH +: UNIT_WIDTH] = u_d;
        assign perm_strb[j] = u_s;
    end

    assign s_ready = ~sk_v_q;
    assign m_valid = or_v_q;
    assign m_data  = or_data_q;
    assign m_strb  = or_strb_q;

    assign acc = s_valid & ~sk_v_q;
    assign pop = or_v_q & m_ready;

    // Next state of output and skid slots; data moves only on loads
    always_comb begin
        or_v_d    = or_v_q;
        sk_v_d    = sk_v_q;
        or_data_d = or_data_q;
        or_strb_d = or_strb_q;
        sk_data_d = sk_data_q;
        sk_strb_d = sk_strb_q;
        if (flush) begin
            or_v_d = 1'b0;
            sk_v_d = 1'b0;
        end else if (!or_v_q) begin
            if (acc) begin
                or_v_d    = 1'b1;
                or_data_d = perm_data;
                or_strb_d = perm_strb;
            end
        end else if (pop) begin
            if (sk_v_q) begin
                sk_v_d    = 1'b0;
                or_data_d = sk_data_q;
                or_strb_d = sk_strb_q;
            end else if (acc) begin
                or_data_d = perm_data;
                or_strb_d = perm_strb;
            end else begin
                or_v_d = 1'b0;
            end
        end else if (acc) begin
            sk_v_d    = 1'b1;
            sk_data_d = perm_data;
            sk_strb_d = perm_strb;
        end
    end

    // Slot registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            or_v_q    <= 1'b0;
            sk_v_q    <= 1'b0;
            or_data_q <= '0;
            or_strb_q <= '0;
            sk_data_q <= '0;
            sk_strb_q <= '0;
        end else begin
            or_v_q    <= or_v_d;
            sk_v_q    <= sk_v_d;
            or_data_q <= or_data_d;
            or_strb_q <= or_strb_d;
            sk_data_q <= sk_data_d;
            sk_strb_q <= sk_strb_d;
        end
    end

endmodule

// File: tb/tb_endian_swap_pipe.sv
// Directed and randomized checks for endian_swap_pipe.
// Covers all modes, backpressure, flush, async reset and widths.
module tb_endian_swap_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        flush = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [63:0] s_data = '0;
    logic [7:0]  s_strb = '0;
    logic [1:0]  s_mode = '0;
    logic        m_valid;
    logic        m_ready = 1'b0;
    logic [63:0] m_data;
    logic [7:0]  m_strb;

    logic        a_s_valid = 1'b0;
    logic        a_s_ready;
    logic [31:0] a_s_data = '0;
    logic [3:0]  a_s_strb = '0;
    logic [1:0]  a_s_mode = '0;
    logic        a_m_valid;
    logic        a_m_ready = 1'b0;
    logic [31:0] a_m_data;
    logic [3:0]  a_m_strb;

    logic         b_s_valid = 1'b0;
    logic         b_s_ready;
    logic [127:0] b_s_data = '0;
    logic [7:0]   b_s_strb = '0;
    logic [1:0]   b_s_mode = '0;
    logic         b_m_valid;
    logic         b_m_ready = 1'b0;
    logic [127:0] b_m_data;
    logic [7:0]   b_m_strb;

    int total = 0;
    int bad = 0;

    always #5 clk = ~clk;

    endian_swap_pipe #(.DATA_WIDTH(64), .UNIT_WIDTH(8)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .s_strb(s_strb), .s_mode(s_mode),
        .m_valid(m_valid), .m_ready(m_ready),
        .m_data(m_data), .m_strb(m_strb)
    );

    endian_swap_pipe #(.DATA_WIDTH(32), .UNIT_WIDTH(8)) dut32 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .s_valid(a_s_valid), .s_ready(a_s_ready), .s_data(a_s_data),
        .s_strb(a_s_strb), .s_mode(a_s_mode),
        .m_valid(a_m_valid), .m_ready(a_m_ready),
        .m_data(a_m_data), .m_strb(a_m_strb)
    );

    endian_swap_pipe #(.DATA_WIDTH(128), .UNIT_WIDTH(16)) dut128 (
        .clk(clk), .rst_n(rst_n), .flush(1'b0),
        .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
        .s_strb(b_s_strb), .s_mode(b_s_mode),
        .m_valid(b_m_valid), .m_ready(b_m_ready),
        .m_data(b_m_data), .m_strb(b_m_strb)
    );

    // Reference: mode 1 = reverse, mode 3 = half swap,
    // mode 2 = reverse followed by half swap.
    function automatic logic [127:0] ref_perm(input logic [127:0] d,
                                              input int n, input int uw,
                                              input logic [1:0] mode);
        logic [127:0] t;
        logic [127:0] r;
        int h;
        h = n / 2;
        t = d;
        if (mode == 2'd1 || mode == 2'd2) begin
            r = '0;
            for (int j = 0; j < n; j++)
                for (int b = 0; b < uw; b++)
                    r[j*uw+b] = t[(n-1-j)*uw+b];
            t = r;
        end
        if (mode == 2'd2 || mode == 2'd3) begin
            r = '0;
            for (int j = 0; j < n; j++)
                for (int b = 0; b < uw; b++)
                    r[j*uw+b] = t[((j+h)%n)*uw+b];
            t = r;
        end
        return t;
    endfunction

    function automatic logic [63:0] bdat(input int i);
        logic [7:0] v;
        v = 8'(i);
        return {8{v}};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [63:0] d, input logic [7:0] st,
                        input logic [1:0] md);
        s_valid = 1'b1;
        s_data  = d;
        s_strb  = st;
        s_mode  = md;
    endtask

    task automatic test_reset();
        #12;
        total++;
        if (m_valid !== 1'b0) begin
            bad++; $display("FAIL reset_mvalid got %b want 0", m_valid);
        end
        total++;
        if (s_ready !== 1'b1) begin
            bad++; $display("FAIL reset_sready got %b want 1", s_ready);
        end
        total++;
        if (m_data !== 64'd0) begin
            bad++; $display("FAIL reset_mdata got %h want 0", m_data);
        end
        total++;
        if (m_strb !== 8'd0) begin
            bad++; $display("FAIL reset_mstrb got %h want 0", m_strb);
        end
        rst_n = 1'b1;
        cyc();
    endtask

    task automatic test_mode1();
        m_ready = 1'b1;
        send(64'h0011223344556677, 8'h0F, 2'd1);
        cyc();
        s_valid = 1'b0;
        total++;
        if (m_valid !== 1'b1) begin
            bad++; $display("FAIL m1_valid got %b want 1", m_valid);
        end
        total++;
        if (m_data !== 64'h7766554433221100) begin
            bad++; $display("FAIL m1_data got %h want 7766554433221100", m_data);
        end
        total++;
        if (m_strb !== 8'hF0) begin
            bad++; $display("FAIL m1_strb got %h want f0", m_strb);
        end
        cyc();
        total++;
        if (m_valid !== 1'b0) begin
            bad++; $display("FAIL m1_drain got %b want 0", m_valid);
        end
    endtask

    task automatic test_back_to_back();
        m_ready = 1'b1;
        send(64'h0011223344556677, 8'h01, 2'd2);
        cyc();
        send(64'h0011223344556677, 8'h0F, 2'd3);
        total++;
        if ({m_valid, m_strb, m_data} !== {1'b1, 8'h08, 64'h3322110077665544}) begin
            bad++;
            $display("FAIL b2b_mode2 got %b %h %h want 1 08 3322110077665544",
                     m_valid, m_strb, m_data);
        end
        cyc();
        s_valid = 1'b0;
        total++;
        if ({m_valid, m_strb, m_data} !== {1'b1, 8'hF0, 64'h4455667700112233}) begin
            bad++;
            $display("FAIL b2b_mode3 got %b %h %h want 1 f0 4455667700112233",
                     m_valid, m_strb, m_data);
        end
        cyc();
    endtask

    task automatic test_backpressure();
        m_ready = 1'b1;
        send(bdat(1), 8'd1, 2'd0);
        cyc();
        total++;
        if (m_data !== bdat(1)) begin
            bad++; $display("FAIL bp_b1 got %h want %h", m_data, bdat(1));
        end
        send(bdat(2), 8'd2, 2'd0);
        cyc();
        total++;
        if ({m_valid, s_ready, m_data} !== {2'b11, bdat(2)}) begin
            bad++; $display("FAIL bp_b2 got %b%b %h want 11 %h",
                            m_valid, s_ready, m_data, bdat(2));
        end
        m_ready = 1'b0;
        send(bdat(3), 8'd3, 2'd0);
        cyc();
        total++;
        if (s_ready !== 1'b0) begin
            bad++; $display("FAIL bp_sready_drop got %b want 0", s_ready);
        end
        send(bdat(4), 8'd4, 2'd0);
        for (int k = 0; k < 2; k++) begin
            total++;
            if ({m_valid, m_data, m_strb} !== {1'b1, bdat(2), 8'd2}) begin
                bad++; $display("FAIL bp_stable got %b %h %h want 1 %h 02",
                                m_valid, m_data, m_strb, bdat(2));
            end
            cyc();
        end
        total++;
        if ({s_ready, m_data} !== {1'b0, bdat(2)}) begin
            bad++; $display("FAIL bp_stall3 got %b %h want 0 %h",
                            s_ready, m_data, bdat(2));
        end
        m_ready = 1'b1;
        cyc();
        total++;
        if ({s_ready, m_data, m_strb} !== {1'b1, bdat(3), 8'd3}) begin
            bad++; $display("FAIL bp_b3 got %b %h %h want 1 %h 03",
                            s_ready, m_data, m_strb, bdat(3));
        end
        for (int k = 4; k <= 6; k++) begin
            cyc();
            if (k < 6) send(bdat(k + 1), 8'(k + 1), 2'd0);
            else s_valid = 1'b0;
            total++;
            if ({m_valid, m_data} !== {1'b1, bdat(k)}) begin
                bad++; $display("FAIL bp_order got %b %h want 1 %h",
                                m_valid, m_data, bdat(k));
            end
        end
        cyc();
        total++;
        if (m_valid !== 1'b0) begin
            bad++; $display("FAIL bp_no_dup got %b %h want 0", m_valid, m_data);
        end
    endtask

    task automatic test_random();
        logic [63:0] qd[$];
        logic [7:0]  qs[$];
        logic [63:0] ed;
        logic [7:0]  es;
        logic [63:0] pr_data;
        logic        pr_ready;
        logic        pr_acc;
        logic        pr_stall;
        int sent;
        int got;
        int cycles;
        sent = 0; got = 0; cycles = 0;
        pr_ready = 1'b0; pr_acc = 1'b0; pr_stall = 1'b0; pr_data = '0;
        while (got < 10000 && cycles < 60000) begin
            s_valid = (sent < 10000) && ($urandom_range(0, 9) < 7);
            s_data  = {$urandom, $urandom};
            s_strb  = 8'($urandom);
            s_mode  = 2'($urandom);
            m_ready = ($urandom_range(0, 9) < 7);
            if (pr_ready) begin
                total++;
                if (s_ready !== 1'b1) begin
                    bad++; $display("FAIL rnd_sready cyc %0d got %b want 1",
                                    cycles, s_ready);
                end
            end
            if (pr_acc) begin
                total++;
                if (m_valid !== 1'b1) begin
                    bad++; $display("FAIL rnd_latency cyc %0d got %b want 1",
                                    cycles, m_valid);
                end
            end
            if (pr_stall) begin
                total++;
                if (m_data !== pr_data) begin
                    bad++; $display("FAIL rnd_stable cyc %0d got %h want %h",
                                    cycles, m_data, pr_data);
                end
            end
            if (m_valid && m_ready) begin
                total++;
                if (qd.size() == 0) begin
                    bad++; $display("FAIL rnd_extra got %h want none", m_data);
                end else begin
                    ed = qd.pop_front();
                    es = qs.pop_front();
                    if ({m_strb, m_data} !== {es, ed}) begin
                        bad++; $display("FAIL rnd_beat %0d got %h %h want %h %h",
                                        got, m_strb, m_data, es, ed);
                    end
                end
                got++;
            end
            if (s_valid && s_ready) begin
                qd.push_back(ref_perm({64'd0, s_data}, 8, 8, s_mode)[63:0]);
                qs.push_back(ref_perm({120'd0, s_strb}, 8, 1, s_mode)[7:0]);
                sent++;
            end
            pr_ready = m_ready;
            pr_acc   = s_valid && s_ready;
            pr_stall = m_valid && !m_ready;
            pr_data  = m_data;
            cyc();
            cycles++;
        end
        s_valid = 1'b0;
        total++;
        if (got != 10000 || qd.size() != 0) begin
            bad++; $display("FAIL rnd_count got %0d left %0d want 10000 0",
                            got, qd.size());
        end
    endtask

    task automatic test_flush();
        m_ready = 1'b0;
        send(bdat(8'hA1), 8'hA1, 2'd0);
        cyc();
        send(bdat(8'hA2), 8'hA2, 2'd1);
        cyc();
        total++;
        if ({m_valid, s_ready} !== 2'b10) begin
            bad++; $display("FAIL fl_full got %b%b want 10", m_valid, s_ready);
        end
        flush = 1'b1;
        send(bdat(8'hA3), 8'hA3, 2'd0);
        cyc();
        total++;
        if ({m_valid, s_ready} !== 2'b01) begin
            bad++; $display("FAIL fl_clear got %b%b want 01", m_valid, s_ready);
        end
        send(bdat(8'hA4), 8'hA4, 2'd0);
        cyc();
        flush = 1'b0;
        s_valid = 1'b0;
        m_ready = 1'b1;
        total++;
        if (m_valid !== 1'b0) begin
            bad++; $display("FAIL fl_concurrent got %b %h want 0", m_valid, m_data);
        end
        cyc();
        send(bdat(8'h55), 8'h55, 2'd0);
        total++;
        if (m_valid !== 1'b0) begin
            bad++; $display("FAIL fl_ghost got %b %h want 0", m_valid, m_data);
        end
        cyc();
        s_valid = 1'b0;
        total++;
        if ({m_valid, m_data} !== {1'b1, bdat(8'h55)}) begin
            bad++; $display("FAIL fl_after got %b %h want 1 %h",
                            m_valid, m_data, bdat(8'h55));
        end
        cyc();
    endtask

    task automatic test_async_reset();
        m_ready = 1'b0;
        send(bdat(8'h77), 8'h77, 2'd0);
        cyc();
        s_valid = 1'b0;
        total++;
        if (m_valid !== 1'b1) begin
            bad++; $display("FAIL ar_pre got %b want 1", m_valid);
        end
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({m_valid, s_ready, m_data} !== {2'b01, 64'd0}) begin
            bad++; $display("FAIL ar_async got %b%b %h want 01 0",
                            m_valid, s_ready, m_data);
        end
        #1;
        rst_n = 1'b1;
        m_ready = 1'b1;
        send(bdat(8'h99), 8'h99, 2'd0);
        cyc();
        s_valid = 1'b0;
        total++;
        if ({m_valid, m_data} !== {1'b1, bdat(8'h99)}) begin
            bad++; $display("FAIL ar_first got %b %h want 1 %h",
                            m_valid, m_data, bdat(8'h99));
        end
        cyc();
    endtask

    task automatic test_sweep();
        logic [127:0] ea;
        logic [127:0] eb;
        logic [127:0] sa;
        logic [127:0] sb;
        a_m_ready = 1'b1;
        b_m_ready = 1'b1;
        for (int md = 0; md < 4; md++) begin
            a_s_valid = 1'b1;
            a_s_data  = 32'h11223344;
            a_s_strb  = 4'b0001;
            a_s_mode  = 2'(md);
            b_s_valid = 1'b1;
            b_s_data  = 128'h00112233445566778899aabbccddeeff;
            b_s_strb  = 8'h13;
            b_s_mode  = 2'(md);
            cyc();
            ea = ref_perm({96'd0, 32'h11223344}, 4, 8, 2'(md));
            sa = ref_perm({124'd0, 4'b0001}, 4, 1, 2'(md));
            eb = ref_perm(128'h00112233445566778899aabbccddeeff, 8, 16, 2'(md));
            sb = ref_perm({120'd0, 8'h13}, 8, 1, 2'(md));
            total++;
            if ({a_m_valid, a_m_strb, a_m_data} !== {1'b1, sa[3:0], ea[31:0]}) begin
                bad++; $display("FAIL sw32 mode %0d got %h %h want %h %h",
                                md, a_m_strb, a_m_data, sa[3:0], ea[31:0]);
            end
            total++;
            if ({b_m_valid, b_m_strb, b_m_data} !== {1'b1, sb[7:0], eb}) begin
                bad++; $display("FAIL sw128 mode %0d got %h %h want %h %h",
                                md, b_m_strb, b_m_data, sb[7:0], eb);
            end
            if (md == 1) begin
                total++;
                if ({a_m_strb, a_m_data} !== {4'b1000, 32'h44332211}) begin
                    bad++; $display("FAIL sw32_m1 got %h %h want 8 44332211",
                                    a_m_strb, a_m_data);
                end
                total++;
                if (b_m_data !== 128'heeffccddaabb88996677445522330011) begin
                    bad++; $display("FAIL sw128_m1 got %h want eeffccddaabb88996677445522330011",
                                    b_m_data);
                end
            end
        end
        a_s_valid = 1'b0;
        b_s_valid = 1'b0;
        cyc();
        total++;
        if ({a_m_valid, b_m_valid} !== 2'b00) begin
            bad++; $display("FAIL sw_drain got %b%b want 00", a_m_valid, b_m_valid);
        end
    endtask

    initial begin
        test_reset();
        test_mode1();
        test_back_to_back();
        test_backpressure();
        test_flush();
        test_async_reset();
        test_sweep();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/endian_swap_pipe.md
Name: endian_swap_pipe

Overview:
Parametrised, pipelined successor to the team's combinational endian swapper, intended for the RV64I load/store datapath between the LSU and the bus interface.
- Selects per transaction among passthrough, full unit reverse, in-half reverse and half swap.
- Permutes the byte strobes identically to the data.
- Wraps the permute in a valid/ready register slice with a 2-entry skid buffer: full throughput, registered ready, 1-cycle latency.

Parameters:
DATA_WIDTH, 64, data bus width in bits; must equal 2*k*UNIT_WIDTH with k >= 1.
UNIT_WIDTH, 8, swap unit width in bits.
(Derived localparam: NUNIT = DATA_WIDTH/UNIT_WIDTH, which is also the strobe width; HUNIT = NUNIT/2.)

Ports:
clk  in  1  clock, rising edge
rst_n  in  1  asynchronous active-low reset
flush  in  1  synchronous clear of all buffered entries
s_valid  in  1  input beat valid
s_ready  out  1  input beat accepted when s_valid&s_ready
s_data  in  DATA_WIDTH  input data
s_strb  in  NUNIT  input unit strobes, bit i qualifies unit i
s_mode  in  2  swap mode for this beat
m_valid  out  1  output beat valid
m_ready  in  1  downstream ready
m_data  out  DATA_WIDTH  permuted data
m_strb  out  NUNIT  permuted strobes

Behaviour:
- Units: unit i = bits [i*UNIT_WIDTH +: UNIT_WIDTH]. Strobe bit i moves with unit i under the same mapping.
- Mode mapping, output unit j takes input unit:
  - 0: j (passthrough).
  - 1: NUNIT-1-j (full reverse).
  - 2: reverse within each half. For j < HUNIT: HUNIT-1-j. For j >= HUNIT: 3*HUNIT-1-j.
  - 3: half swap, (j+HUNIT) mod NUNIT. Unit order inside each half is kept.
- Permute is combinational on the input side and is captured together with the beat. s_mode is sampled only on acceptance.
- Storage is an output register (OR) plus a skid register (SK), each with its own valid bit.
  - m_valid = OR valid; m_data and m_strb come from OR.
  - s_ready = ~SK valid, taken directly from a flop, not combinational from m_ready.
- Per cycle, with acc = s_valid&s_ready and pop = m_valid&m_ready:
  - OR empty, acc: OR <= beat. Output appears the next cycle (latency 1).
  - OR full, pop, SK empty, acc: OR <= beat.
  - OR full, pop, SK full: OR <= SK and SK is cleared. acc is impossible here since s_ready=0.
  - OR full, no pop, acc: SK <= beat, so s_ready drops the next cycle.
  - OR full, pop, no acc, SK empty: OR becomes empty.
- Ordering: strictly FIFO. No beat is dropped or duplicated.
- Throughput: 1 beat/cycle sustained while m_ready=1.
- Backpressure: after m_ready deasserts, at most one further beat is accepted, into SK.
- Output stability: while m_valid=1 and m_ready=0, m_data and m_strb hold stable.
- flush: next edge clears both valid bits. Any acc in the same cycle is discarded. s_ready=1 the cycle after.
- Reset, asynchronous, active-low: OR and SK valid = 0, m_valid = 0, s_ready = 1, m_data = 0, m_strb = 0. Data registers also reset to 0.
- Data registers in OR/SK load only on the load cases above (no toggling when idle).

Test Plan:
- Mode 1: s_data=0x0011223344556677, s_strb=0x0F, m_ready=1 → next cycle m_data=0x7766554433221100, m_strb=0xF0, m_valid=1.
- Mode 2, then mode 3, back-to-back:
  - Beat 1 (mode 2): s_data=0x0011223344556677, s_strb=0x01 → m_data=0x3322110077665544, m_strb=0x08.
  - Beat 2 (mode 3): same data, s_strb=0x0F → m_data=0x4455667700112233, m_strb=0xF0, on consecutive cycles.
- Backpressure: stream beats 1..6 with mode 0.
  - Drop m_ready for 3 cycles after beat 2 is shown → s_ready falls 1 cycle later.
  - Beat 3 is held in SK. The output order is 1..6, with no loss or duplication.
  - m_data stays stable while stalled.
- Random valid/ready, 10k beats, random modes, against a reference model → exact in-order match, with throughput 1 beat/cycle during spans where m_ready=1.
- With OR and SK both full, assert flush together with s_valid → next cycle m_valid=0, s_ready=1, and the flushed and concurrent beats never appear.
- Pull rst_n low asynchronously mid-stream, between edges → m_valid=0, s_ready=1, m_data=0 immediately. After release, the first beat passes with latency 1.
- Parameter sweep DATA_WIDTH=32/UNIT_WIDTH=8 and DATA_WIDTH=128/UNIT_WIDTH=16 → mode 1 on 32-bit 0x11223344 gives 0x44332211, and all modes match the reference model.
